// File: rtl/genesis_pad_pkg.sv
// rtl/genesis_pad_pkg.sv - shared constants for the Genesis multi-pad scanner
package genesis_pad_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SCAN   = 2'd1;
    localparam state_t ST_COMMIT = 2'd2;
    localparam state_t ST_GAP    = 2'd3;

    // Published button vector layout, bit11..bit0
    localparam int BTN_UP    = 11;
    localparam int BTN_DOWN  = 10;
    localparam int BTN_LEFT  = 9;
    localparam int BTN_RIGHT = 8;
    localparam int BTN_A     = 7;
    localparam int BTN_B     = 6;
    localparam int BTN_C     = 5;
    localparam int BTN_X     = 4;
    localparam int BTN_Y     = 3;
    localparam int BTN_Z     = 2;
    localparam int BTN_START = 1;
    localparam int BTN_MODE  = 0;

    localparam int PIN_UP_Z       = 0;
    localparam int PIN_DOWN_Y     = 1;
    localparam int PIN_LEFT_X     = 2;
    localparam int PIN_RIGHT_MODE = 3;
    localparam int PIN_A_B        = 4;
    localparam int PIN_START_C    = 5;

    localparam logic [11:0] SIX_ONLY_MASK = (12'd1 << BTN_X) | (12'd1 << BTN_Y)
                                          | (12'd1 << BTN_Z) | (12'd1 << BTN_MODE);

endpackage

// File: rtl/genesis_pad_lane.sv
// rtl/genesis_pad_lane.sv - per-pad synchroniser, phase sampling, masking and edge detect
module genesis_pad_lane
    import genesis_pad_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  pins_i,
    input  logic        sample_i,
    input  logic [2:0]  phase_i,
    input  logic        commit_i,
    output logic [11:0] buttons_o,
    output logic [11:0] pressed_o,
    output logic        present_o,
    output logic        six_o
);

    logic [5:0]  sync1_q, sync2_q, act;
    logic [11:0] shadow_q, shadow_d, masked, buttons_q, pressed_q;
    logic        present_sh_q, present_sh_d, six_sh_q, six_sh_d, present_q, six_q;

    assign act = ~sync2_q;

    always_comb begin
        shadow_d     = shadow_q;
        present_sh_d = present_sh_q;
        six_sh_d     = six_sh_q;
        if (sample_i) begin
            case (phase_i)
                3'd1: begin
                    shadow_d[BTN_A]     = act[PIN_A_B];
                    shadow_d[BTN_START] = act[PIN_START_C];
                    // Both LEFT and RIGHT grounded while select is low identifies a connected pad
                    present_sh_d        = act[PIN_LEFT_X] & act[PIN_RIGHT_MODE];
                end
                3'd2: begin
                    shadow_d[BTN_UP]    = act[PIN_UP_Z];
                    shadow_d[BTN_DOWN]  = act[PIN_DOWN_Y];
                    shadow_d[BTN_LEFT]  = act[PIN_LEFT_X];
                    shadow_d[BTN_RIGHT] = act[PIN_RIGHT_MODE];
                end
                3'd4: begin
                    shadow_d[BTN_B] = act[PIN_A_B];
                    shadow_d[BTN_C] = act[PIN_START_C];
                end
                3'd5: six_sh_d = &act[3:0];
                3'd6: begin
                    shadow_d[BTN_Z]    = act[PIN_UP_Z];
                    shadow_d[BTN_Y]    = act[PIN_DOWN_Y];
                    shadow_d[BTN_X]    = act[PIN_LEFT_X];
                    shadow_d[BTN_MODE] = act[PIN_RIGHT_MODE];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        masked = '0;
        if (present_sh_q) begin
            masked = six_sh_q ? shadow_q : (shadow_q & ~SIX_ONLY_MASK);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            shadow_q     <= '0;
            present_sh_q <= 1'b0;
            six_sh_q     <= 1'b0;
            buttons_q    <= '0;
            pressed_q    <= '0;
            present_q    <= 1'b0;
            six_q        <= 1'b0;
        end else begin
            sync1_q      <= pins_i;
            sync2_q      <= sync1_q;
            shadow_q     <= shadow_d;
            present_sh_q <= present_sh_d;
            six_sh_q     <= six_sh_d;
            pressed_q    <= '0;
            if (commit_i) begin
                buttons_q <= masked;
                pressed_q <= masked & ~buttons_q;
                present_q <= present_sh_q;
                six_q     <= present_sh_q & six_sh_q;
            end
        end
    end

    assign buttons_o = buttons_q;
    assign pressed_o = pressed_q;
    assign present_o = present_q;
    assign six_o     = six_q;

endmodule

// File: rtl/genesis_pad_scanner.sv
// rtl/genesis_pad_scanner.sv - shared-select sequencer scanning NUM_PADS Mega Drive pads
module genesis_pad_scanner
    import genesis_pad_pkg::*;
#(
    parameter int NUM_PADS     = 2,
    parameter int PHASE_CYCLES = 1000,
    parameter int GAP_CYCLES   = 100000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_PADS*6-1:0]    pad_pins,
    output logic                     select,
    output logic [NUM_PADS*12-1:0]   buttons,
    output logic [NUM_PADS*12-1:0]   pressed,
    output logic [NUM_PADS-1:0]      present,
    output logic [NUM_PADS-1:0]      six_button,
    output logic                     scan_done
);

    localparam int CW = $clog2(PHASE_CYCLES);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t        state_q, state_d;
    logic [2:0]    ph_q, ph_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          done_q, phase_last;

    assign phase_last = (state_q == ST_SCAN) && (cnt_q == CW'(PHASE_CYCLES - 1));
    assign select     = (state_q == ST_SCAN) ? ~ph_q[0] : 1'b1;
    assign scan_done  = done_q;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_SCAN;
                    ph_d    = '0;
                    cnt_d   = '0;
                end
            end
            ST_SCAN: begin
                if (phase_last) begin
                    cnt_d = '0;
                    if (ph_q == 3'd7) state_d = ST_COMMIT;
                    else              ph_d    = ph_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_COMMIT: begin
                state_d = ST_GAP;
                gap_d   = '0;
            end
            default: begin
                // enable is only consulted here and in IDLE, so a scan in flight always completes
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = enable ? ST_SCAN : ST_IDLE;
                    ph_d    = '0;
                    cnt_d   = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            done_q  <= (state_q == ST_COMMIT);
        end
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_lane
        genesis_pad_lane u_lane (
            .clock     (clock),
            .reset     (reset),
            .pins_i    (pad_pins[6*p +: 6]),
            .sample_i  (phase_last),
            .phase_i   (ph_q),
            .commit_i  (state_q == ST_COMMIT),
            .buttons_o (buttons[12*p +: 12]),
            .pressed_o (pressed[12*p +: 12]),
            .present_o (present[p]),
            .six_o     (six_button[p])
        );
    end

endmodule

// File: tb/tb_genesis_pad_scanner.sv
// tb/tb_genesis_pad_scanner.sv - scoreboard bench with behavioural 3/6-button pad models
module tb_genesis_pad_scanner;

    localparam int NP = 2;
    localparam int PC = 4;
    localparam int GC = 8;

    localparam logic [11:0] B_UP    = 12'h800;
    localparam logic [11:0] B_LEFT  = 12'h200;
    localparam logic [11:0] B_RIGHT = 12'h100;
    localparam logic [11:0] B_A     = 12'h080;
    localparam logic [11:0] B_X     = 12'h010;
    localparam logic [11:0] B_MODE  = 12'h001;
    localparam logic [11:0] XYZM    = 12'h01D;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [11:0]   pad_pins;
    logic          select;
    logic [23:0]   buttons, pressed;
    logic [1:0]    present, six_button;
    logic          scan_done;

    int compared   = 0;
    int mismatched = 0;

    genesis_pad_scanner #(.NUM_PADS(NP), .PHASE_CYCLES(PC), .GAP_CYCLES(GC)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .pad_pins   (pad_pins),
        .select     (select),
        .buttons    (buttons),
        .pressed    (pressed),
        .present    (present),
        .six_button (six_button),
        .scan_done  (scan_done)
    );

    always #5 clock = ~clock;

    // Pad model: type 0 absent, 1 three-button, 2 six-button; held is active-high in output layout
    int          pad_type [NP];
    logic [11:0] held [NP];
    int          lowcnt   = 0;
    int          high_run = 0;
    logic        prev_sel = 1'b1;

    always @(posedge clock) begin
        prev_sel <= select;
        high_run <= select ? high_run + 1 : 0;
        if (prev_sel && !select) lowcnt <= lowcnt + 1;
        else if (high_run >= 6)  lowcnt <= 0;
    end

    function automatic logic [5:0] pad_drive(input int t, input logic [11:0] h, input logic sel, input int lc);
        logic [5:0] a;
        if (t == 0) return 6'h3F;
        if (sel) begin
            if (t == 2 && lc == 3) a = {h[5], h[6], h[0], h[4], h[3], h[2]};
            else                   a = {h[5], h[6], h[8], h[9], h[10], h[11]};
        end else begin
            if (t == 2 && lc == 3)      a = {h[1], h[7], 4'b1111};
            else if (t == 2 && lc == 4) a = {h[1], h[7], 4'b0000};
            else                        a = {h[1], h[7], 2'b11, h[10], h[11]};
        end
        return ~a;
    endfunction

    always_comb begin
        pad_pins = {pad_drive(pad_type[1], held[1], select, lowcnt),
                    pad_drive(pad_type[0], held[0], select, lowcnt)};
    end

    typedef struct packed {
        logic [23:0] b;
        logic [23:0] p;
        logic [1:0]  pr;
        logic [1:0]  six;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [23:0] exp_prev = '0;
    bit          ok;
    int          n;

    task automatic push_scan();
        exp_t        x;
        logic [11:0] nb;
        for (int p = 0; p < NP; p++) begin
            if (pad_type[p] == 0)      nb = '0;
            else if (pad_type[p] == 1) nb = held[p] & ~XYZM;
            else                       nb = held[p];
            x.b[12*p +: 12] = nb;
            x.pr[p]  = (pad_type[p] != 0);
            x.six[p] = (pad_type[p] == 2);
        end
        x.p      = x.b & ~exp_prev;
        exp_prev = x.b;
        exp_q.push_back(x);
    endtask

    task automatic wait_scan(output bit got, output int cycles);
        got = 0;
        cycles = 0;
        while (!got && cycles < 200) begin
            @(negedge clock);
            cycles++;
            if (scan_done === 1'b1) got = 1;
        end
    endtask

    task automatic pop_expected();
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        compared++;
        if (select !== 1'b1) begin mismatched++; $display("FAIL reset_select: got %b want 1", select); end
        compared++;
        if ({buttons, pressed, present, six_button, scan_done} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got b=%h p=%h pr=%b six=%b done=%b want all 0", buttons, pressed, present, six_button, scan_done);
        end
    endtask

    task automatic test_no_pads();
        int sel_bad = 0;
        int done_bad = 0;
        logic exp_sel;
        pad_type[0] = 0; pad_type[1] = 0; held[0] = '0; held[1] = '0;
        push_scan();
        push_scan();
        enable = 1'b1;
        reset = 1'b0;
        wait_scan(ok, n);
        pop_expected();
        compared++;
        if (!ok || {buttons, pressed, present, six_button} !== {e.b, e.p, e.pr, e.six}) begin
            mismatched++;
            $display("FAIL no_pads_scan1: got ok=%0d b=%h p=%h pr=%b six=%b want b=%h p=%h pr=%b six=%b", ok, buttons, pressed, present, six_button, e.b, e.p, e.pr, e.six);
        end
        for (int i = 1; i <= 41; i++) begin
            @(negedge clock);
            exp_sel = 1'b1;
            if (i >= 8 && i <= 39) exp_sel = (((i - 8) / PC) % 2) == 0;
            if (select !== exp_sel) sel_bad++;
            if (scan_done !== (i == 41)) done_bad++;
        end
        compared++;
        if (sel_bad != 0) begin mismatched++; $display("FAIL select_pattern: got %0d wrong cycles want 0", sel_bad); end
        compared++;
        if (done_bad != 0) begin mismatched++; $display("FAIL scan_period: got %0d misplaced strobes want 0 (period 41)", done_bad); end
        pop_expected();
        compared++;
        if ({buttons, pressed, present, six_button} !== {e.b, e.p, e.pr, e.six}) begin
            mismatched++;
            $display("FAIL no_pads_scan2: got b=%h p=%h pr=%b want b=%h p=%h pr=%b", buttons, pressed, present, e.b, e.p, e.pr);
        end
    endtask

    task automatic test_three_button();
        pad_type[0] = 1; held[0] = B_A | B_UP;
        push_scan();
        push_scan();
        for (int k = 0; k < 2; k++) begin
            wait_scan(ok, n);
            pop_expected();
            compared++;
            if (!ok || {buttons, pressed, present, six_button} !== {e.b, e.p, e.pr, e.six}) begin
                mismatched++;
                $display("FAIL three_scan%0d: got ok=%0d b=%h p=%h pr=%b six=%b want b=%h p=%h pr=%b six=%b", k, ok, buttons, pressed, present, six_button, e.b, e.p, e.pr, e.six);
            end
            if (k == 0) begin
                @(negedge clock);
                compared++;
                if (pressed !== '0 || scan_done !== 1'b0) begin
                    mismatched++;
                    $display("FAIL pressed_one_cycle: got p=%h done=%b want 0 0", pressed, scan_done);
                end
            end
        end
    endtask

    task automatic test_six_button();
        pad_type[0] = 0; held[0] = '0;
        pad_type[1] = 2; held[1] = B_X | B_MODE;
        push_scan();
        push_scan();
        for (int k = 0; k < 2; k++) begin
            wait_scan(ok, n);
            pop_expected();
            compared++;
            if (!ok || {buttons, pressed, present, six_button} !== {e.b, e.p, e.pr, e.six}) begin
                mismatched++;
                $display("FAIL six_scan%0d: got ok=%0d b=%h p=%h pr=%b six=%b want b=%h p=%h pr=%b six=%b", k, ok, buttons, pressed, present, six_button, e.b, e.p, e.pr, e.six);
            end
        end
    endtask

    task automatic test_three_xyz_mask();
        pad_type[0] = 1; held[0] = B_LEFT | B_RIGHT;
        push_scan();
        wait_scan(ok, n);
        pop_expected();
        compared++;
        if (!ok || {buttons, pressed, present, six_button} !== {e.b, e.p, e.pr, e.six}) begin
            mismatched++;
            $display("FAIL xyz_scan: got ok=%0d b=%h p=%h pr=%b six=%b want b=%h p=%h pr=%b six=%b", ok, buttons, pressed, present, six_button, e.b, e.p, e.pr, e.six);
        end
        compared++;
        if ((buttons[11:0] & XYZM) !== 12'h000) begin
            mismatched++;
            $display("FAIL xyz_masked: got %h want 000", buttons[11:0] & XYZM);
        end
    endtask

    task automatic test_enable_drop();
        int idle_bad = 0;
        int sel_bad = 0;
        logic [7:0] sel_seen;
        push_scan();
        repeat (21) @(negedge clock);
        enable = 1'b0;
        wait_scan(ok, n);
        pop_expected();
        compared++;
        if (!ok || {buttons, pressed, present, six_button} !== {e.b, e.p, e.pr, e.six}) begin
            mismatched++;
            $display("FAIL drop_scan: got ok=%0d b=%h p=%h want b=%h p=%h", ok, buttons, pressed, e.b, e.p);
        end
        repeat (30) begin
            @(negedge clock);
            if (select !== 1'b1 || scan_done !== 1'b0) idle_bad++;
        end
        compared++;
        if (idle_bad != 0) begin mismatched++; $display("FAIL idle_hold: got %0d active cycles want 0", idle_bad); end
        enable = 1'b1;
        push_scan();
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            sel_seen[7-i] = select;
        end
        compared++;
        if (sel_seen !== 8'hF0) begin mismatched++; $display("FAIL restart_ph0: got %b want 11110000", sel_seen); end
        wait_scan(ok, n);
        pop_expected();
        compared++;
        if (!ok || {buttons, pressed, present, six_button} !== {e.b, e.p, e.pr, e.six}) begin
            mismatched++;
            $display("FAIL restart_scan: got ok=%0d b=%h p=%h want b=%h p=%h", ok, buttons, pressed, e.b, e.p);
        end
        if (sel_bad != 0) mismatched++;
    endtask

    task automatic test_reset_mid_scan();
        repeat (29) @(negedge clock);
        reset = 1'b1;
        #1;
        compared++;
        if (select !== 1'b1 || {buttons, pressed, present, six_button, scan_done} !== '0) begin
            mismatched++;
            $display("FAIL reset_mid: got sel=%b b=%h p=%h pr=%b six=%b done=%b want 1 and all 0", select, buttons, pressed, present, six_button, scan_done);
        end
        repeat (10) @(negedge clock);
        exp_prev = '0;
        push_scan();
        reset = 1'b0;
        wait_scan(ok, n);
        compared++;
        if (!ok || n != 34) begin mismatched++; $display("FAIL fresh_scan_latency: got %0d cycles want 34", n); end
        pop_expected();
        compared++;
        if ({buttons, pressed, present, six_button} !== {e.b, e.p, e.pr, e.six}) begin
            mismatched++;
            $display("FAIL fresh_scan: got b=%h p=%h pr=%b six=%b want b=%h p=%h pr=%b six=%b", buttons, pressed, present, six_button, e.b, e.p, e.pr, e.six);
        end
    endtask

    initial begin
        pad_type[0] = 0; pad_type[1] = 0;
        held[0] = '0; held[1] = '0;
        test_reset();
        test_no_pads();
        test_three_button();
        test_six_button();
        test_three_xyz_mask();
        test_enable_drop();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
